// File: rtl/reconf_fir_filter_pkg.sv
// rtl/reconf_fir_filter_pkg.sv - shared widths, tap count and output saturation for the FIR
package reconf_fir_filter_pkg;

    localparam int NUM_TAPS = 33;
    localparam int COEF_W   = 16;
    localparam int IN_W     = 3;
    localparam int ACC_W    = 25;
    localparam int OUT_W    = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 25'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -25'sd32768;

    function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] lim;
        lim = acc;
        if (acc > SAT_MAX) begin
            lim = SAT_MAX;
        end else if (acc < SAT_MIN) begin
            lim = SAT_MIN;
        end
        return lim[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fir_tap_cell.sv
// rtl/fir_tap_cell.sv - one transposed-form stage: coef*sample plus the next partial sum
module fir_tap_cell
    import reconf_fir_filter_pkg::*;
#(
    parameter int COEF_W = reconf_fir_filter_pkg::COEF_W
) (
    input  logic                     clk12M,
    input  logic                     rst,
    input  logic                     sampleEn,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [ACC_W-1:0]  zNext,
    output logic signed [ACC_W-1:0]  zCur
);

    localparam int PROD_W = COEF_W + IN_W;

    logic signed [PROD_W-1:0] product;

    assign product = PROD_W'(coef) * PROD_W'(sample);

    always_ff @(posedge clk12M or posedge rst) begin
        if (rst) begin
            zCur <= '0;
        end else if (sampleEn) begin
            zCur <= ACC_W'(product) + zNext;
        end
    end

endmodule

// File: rtl/reconf_fir_filter.sv
// rtl/reconf_fir_filter.sv - transposed-form FIR with a writable coefficient register file
module reconf_fir_filter
    import reconf_fir_filter_pkg::*;
#(
    parameter int NUM_TAPS = reconf_fir_filter_pkg::NUM_TAPS,
    parameter int COEF_W   = reconf_fir_filter_pkg::COEF_W
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iEnSample_300k,
    input  logic                     iCoeffiUpdateFlag,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [3:0]               iAddrRam,
    input  logic signed [COEF_W-1:0] iWrDtRam,
    input  logic [5:0]               iNumOfCoeff,
    input  logic signed [IN_W-1:0]   iFirIn,
    output logic signed [OUT_W-1:0]  oFirOut
);

    localparam int PROD_W = COEF_W + IN_W;

    logic signed [COEF_W-1:0] coef [NUM_TAPS];
    logic signed [ACC_W-1:0]  zChain [1:NUM_TAPS];
    logic signed [PROD_W-1:0] prod0;
    logic signed [ACC_W-1:0]  sum0;
    logic                     wrEn;
    logic                     unusedAddr;

    // Bank addressing is reserved; the pins exist only for interface compatibility.
    assign unusedAddr = ^iAddrRam;

    assign wrEn = iCoeffiUpdateFlag && !iCsnRam && !iWrnRam
                  && (int'(iNumOfCoeff) < NUM_TAPS);

    always_ff @(posedge iClk_12M or posedge iRsn) begin
        if (iRsn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (wrEn) begin
            coef[iNumOfCoeff] <= iWrDtRam;
        end
    end

    // The last stage has no successor, so its partial-sum input is tied to zero.
    assign zChain[NUM_TAPS] = '0;

    for (genvar k = 1; k < NUM_TAPS; k++) begin : gTap
        fir_tap_cell #(
            .COEF_W(COEF_W)
        ) uTap (
            .clk12M  (iClk_12M),
            .rst     (iRsn),
            .sampleEn(iEnSample_300k),
            .coef    (coef[k]),
            .sample  (iFirIn),
            .zNext   (zChain[k+1]),
            .zCur    (zChain[k])
        );
    end

    assign prod0 = PROD_W'(coef[0]) * PROD_W'(iFirIn);
    assign sum0  = ACC_W'(prod0) + zChain[1];

    always_ff @(posedge iClk_12M or posedge iRsn) begin
        if (iRsn) begin
            oFirOut <= '0;
        end else if (iEnSample_300k) begin
            oFirOut <= sat16(sum0);
        end
    end

endmodule

// File: tb/tb_reconf_fir_filter.sv
// tb/tb_reconf_fir_filter.sv - randomized self-checking bench against a snapshot-product FIR model
module tb_reconf_fir_filter;

    localparam int NT = 33;

    logic              iClk_12M = 1'b0;
    logic              iRsn;
    logic              iEnSample_300k;
    logic              iCoeffiUpdateFlag;
    logic              iCsnRam;
    logic              iWrnRam;
    logic [3:0]        iAddrRam;
    logic signed [15:0] iWrDtRam;
    logic [5:0]        iNumOfCoeff;
    logic signed [2:0] iFirIn;
    logic signed [15:0] oFirOut;

    reconf_fir_filter dut (
        .iClk_12M         (iClk_12M),
        .iRsn             (iRsn),
        .iEnSample_300k   (iEnSample_300k),
        .iCoeffiUpdateFlag(iCoeffiUpdateFlag),
        .iCsnRam          (iCsnRam),
        .iWrnRam          (iWrnRam),
        .iAddrRam         (iAddrRam),
        .iWrDtRam         (iWrDtRam),
        .iNumOfCoeff      (iNumOfCoeff),
        .iFirIn           (iFirIn),
        .oFirOut          (oFirOut)
    );

    always #42 iClk_12M = ~iClk_12M;

    int checkCount = 0;
    int passCount  = 0;

    // Model: each sample keeps the product vector formed with the coefficients
    // live at that moment; output n sums product k of the sample k strobes ago.
    int mCoef [NT];
    int mHist [NT][NT];
    int mExp;
    int impTbl [NT];

    task automatic checkVal(input string tag, input int got, input int exp);
        checkCount++;
        if (got == exp) passCount++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int satModel(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            mCoef[i] = 0;
            for (int j = 0; j < NT; j++) mHist[i][j] = 0;
        end
        mExp = 0;
    endtask

    task automatic modelSample(input int x);
        int acc;
        for (int i = NT - 1; i > 0; i--)
            for (int j = 0; j < NT; j++) mHist[i][j] = mHist[i-1][j];
        for (int j = 0; j < NT; j++) mHist[0][j] = mCoef[j] * x;
        acc = 0;
        for (int k = 0; k < NT; k++) acc += mHist[k][k];
        mExp = satModel(acc);
    endtask

    task automatic modelWrite(input int idx, input int data, input bit flag, input bit csn, input bit wrn);
        logic signed [15:0] d16;
        d16 = data[15:0];
        if (flag && !csn && !wrn && idx < NT) mCoef[idx] = int'(d16);
    endtask

    task automatic tick();
        @(posedge iClk_12M);
        #1;
    endtask

    task automatic driveWrite(input int idx, input int data, input bit flag, input bit csn, input bit wrn);
        iCoeffiUpdateFlag = flag;
        iCsnRam = csn;
        iWrnRam = wrn;
        iNumOfCoeff = 6'(idx);
        iWrDtRam = 16'(data);
        iAddrRam = 4'($urandom);
    endtask

    task automatic releaseWrite();
        iCoeffiUpdateFlag = 1'b0;
        iCsnRam = 1'b1;
        iWrnRam = 1'b1;
    endtask

    task automatic writeCoef(input int idx, input int data, input bit flag, input bit csn, input bit wrn);
        driveWrite(idx, data, flag, csn, wrn);
        tick();
        releaseWrite();
        modelWrite(idx, data, flag, csn, wrn);
    endtask

    task automatic idleGap(input string tag);
        for (int i = 0; i < 39; i++) begin
            iFirIn = 3'($urandom);
            tick();
        end
        checkVal({tag, "_hold"}, int'(oFirOut), mExp);
    endtask

    task automatic strobe(input int x, input string tag);
        iFirIn = 3'(x);
        iEnSample_300k = 1'b1;
        modelSample(x);
        tick();
        iEnSample_300k = 1'b0;
        checkVal(tag, int'(oFirOut), mExp);
        idleGap(tag);
    endtask

    task automatic strobeWrite(input int x, input int idx, input int data, input string tag);
        iFirIn = 3'(x);
        iEnSample_300k = 1'b1;
        driveWrite(idx, data, 1'b1, 1'b0, 1'b0);
        modelSample(x);
        tick();
        iEnSample_300k = 1'b0;
        releaseWrite();
        modelWrite(idx, data, 1'b1, 1'b0, 1'b0);
        checkVal(tag, int'(oFirOut), mExp);
        idleGap(tag);
    endtask

    task automatic loadTable();
        for (int k = 0; k < NT; k++) writeCoef(k, impTbl[k], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic impulseRun(input int amp, input string tag);
        strobe(amp, tag);
        checkVal({tag, "_first"}, int'(oFirOut), amp * impTbl[0]);
        for (int i = 1; i < NT; i++) begin
            strobe(0, tag);
            if (i == 3) checkVal({tag, "_tap3"}, int'(oFirOut), amp * impTbl[3]);
        end
        checkVal({tag, "_last"}, int'(oFirOut), amp * impTbl[NT-1]);
        strobe(0, tag);
        checkVal({tag, "_tail"}, int'(oFirOut), 0);
    endtask

    initial begin
        iRsn = 1'b1;
        iEnSample_300k = 1'b0;
        iFirIn = '0;
        iAddrRam = '0;
        iWrDtRam = '0;
        iNumOfCoeff = '0;
        releaseWrite();
        modelReset();
        repeat (3) tick();
        checkVal("reset_out", int'(oFirOut), 0);
        iRsn = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) impTbl[k] = k + 1;
        for (int k = 10; k < 20; k++) impTbl[k] = 'h11 + k - 10;
        for (int k = 20; k < 30; k++) impTbl[k] = 'h21 + k - 20;
        for (int k = 30; k < NT; k++) impTbl[k] = 'h31 + k - 30;

        loadTable();
        impulseRun(1, "imp_pos");
        impulseRun(-4, "imp_neg");

        writeCoef(40, 'h7FFF, 1'b1, 1'b0, 1'b0);
        writeCoef(63, 'h1234, 1'b1, 1'b0, 1'b0);
        writeCoef(3, 'h7FFF, 1'b1, 1'b1, 1'b0);
        writeCoef(3, 'h7FFF, 1'b0, 1'b0, 1'b0);
        writeCoef(3, 'h7FFF, 1'b1, 1'b0, 1'b1);
        impulseRun(1, "gated");

        strobeWrite(1, 0, 50, "same_cycle");
        checkVal("same_cycle_old", int'(oFirOut), 1);
        writeCoef(7, 100, 1'b1, 1'b0, 1'b0);
        writeCoef(7, -200, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NT + 2; i++) strobe(i == 0 ? 1 : 0, "lww");

        for (int k = 0; k < NT; k++) writeCoef(k, 'h7FFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) strobe(3, "sat_pos");
        checkVal("sat_pos_clamp", int'(oFirOut), 32767);
        for (int i = 0; i < 36; i++) strobe(-4, "sat_neg");
        checkVal("sat_neg_clamp", int'(oFirOut), -32768);

        for (int k = 0; k < NT; k++) writeCoef(k, int'($urandom), 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 150; n++) begin
            int x;
            x = int'($urandom_range(0, 7)) - 4;
            if ($urandom_range(0, 3) == 0)
                writeCoef(int'($urandom_range(0, 45)), int'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)
                strobeWrite(x, int'($urandom_range(0, NT - 1)), int'($urandom), "rand_sw");
            else
                strobe(x, "rand");
        end

        driveWrite(5, 'h4321, 1'b1, 1'b0, 1'b0);
        iEnSample_300k = 1'b1;
        iFirIn = 3'sd3;
        #5;
        iRsn = 1'b1;
        #5;
        modelReset();
        checkVal("midreset_async", int'(oFirOut), 0);
        repeat (2) tick();
        iEnSample_300k = 1'b0;
        releaseWrite();
        iRsn = 1'b0;
        tick();
        for (int n = 0; n < 10; n++) begin
            strobe(int'($urandom_range(0, 7)) - 4, "post_reset");
            checkVal("post_reset_zero", int'(oFirOut), 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
